// File: rtl/mult_defs.sv
// Shared definitions for the sequential shift-and-add multiplier: operand
// width, iteration counter width and control state encoding.
package mult_defs;

  localparam int N     = 16;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/rca_32bit.sv
// 32-bit ripple-carry adder from the adder library: a chain of full-adder
// cells, carry rippling from bit 0 upward.
module rca_32bit (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [32:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign sum[i]       = in1[i] ^ in2[i] ^ carry_s[i];
    assign carry_s[i+1] = (in1[i] & in2[i]) | (carry_s[i] & (in1[i] ^ in2[i]));
  end

  assign cout = carry_s[32];

endmodule

// File: rtl/seq_mult_16x16.sv
// Unsigned 16x16 -> 32 shift-and-add multiplier: one partial product per
// cycle through a single rca_32bit, fixed 17-cycle latency from accept to done.
module seq_mult_16x16
  import mult_defs::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     in1,
  input  logic [N-1:0]     in2,
  output logic [2*N-1:0]   product,
  output logic             busy,
  output logic             done
);

  state_e             state_q, state_d;
  logic [2*N-1:0]     mcand_q, mcand_d;
  logic [N-1:0]       mplier_q, mplier_d;
  logic [2*N-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]     product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [2*N-1:0]     addend_s;
  logic [2*N-1:0]     sum_s;
  logic               adder_cout_s;
  logic [2*N-1:0]     acc_next_s;
  logic               last_iter_s;

  // mcand carries 16 zero MSBs, so a shift of at most 15 never loses bits.
  assign addend_s    = mcand_q << cnt_q;
  assign acc_next_s  = mplier_q[0] ? sum_s : acc_q;
  assign last_iter_s = (cnt_q == CNT_W'(N - 1));

  rca_32bit u_rca (
    .in1  (acc_q),
    .in2  (addend_s),
    .cin  (1'b0),
    .sum  (sum_s),
    .cout (adder_cout_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
        else       state_d = IDLE;
      end
      RUN: begin
        if (last_iter_s) state_d = DONE;
        else             state_d = RUN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so busy/done come straight from flops
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      IDLE:    begin busy_d = 1'b0; done_d = 1'b0; end
      RUN:     begin busy_d = 1'b1; done_d = 1'b0; end
      DONE:    begin busy_d = 1'b0; done_d = 1'b1; end
      default: begin busy_d = 1'b0; done_d = 1'b0; end
    endcase
  end

  // Datapath next-state: operand capture, accumulate/shift, result update
  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{N{1'b0}}, in1};
          mplier_d = in2;
          acc_d    = {(2*N){1'b0}};
          cnt_d    = {CNT_W{1'b0}};
        end else begin
          mcand_d  = mcand_q;
        end
      end
      RUN: begin
        acc_d    = acc_next_s;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_iter_s) product_d = acc_next_s;
        else             product_d = product_q;
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= {(2*N){1'b0}};
      mplier_q  <= {N{1'b0}};
      acc_q     <= {(2*N){1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      product_q <= {(2*N){1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_mult_16x16.sv
// Self-checking bench for seq_mult_16x16; the reference result is plain
// multiplication and the reference timing is the fixed 17-edge latency.
module tb_seq_mult_16x16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [31:0] product;
  logic        busy;
  logic        done;

  int n_checks;
  int n_fail;

  localparam int LAT = 17;

  seq_mult_16x16 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .in1     (in1),
    .in2     (in2),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    return 32'(a) * 32'(b);
  endfunction

  // Starts one operation and follows it to done. lat counts posedges from the
  // accept edge (inclusive) to the edge after which done is visible.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit scramble,
                       output int lat, output int busy_cycles, output logic [31:0] prod);
    @(negedge clk);
    start = 1'b1; in1 = a; in2 = b;
    @(posedge clk);
    lat = 1; busy_cycles = 0;
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin
      in1 = 16'($urandom); in2 = 16'($urandom);
    end
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cycles++;
      n_checks++;
      if (dut.adder_cout_s !== 1'b0) begin
        n_fail++;
        $display("FAIL adder_cout: got %b want 0 (lat %0d)", dut.adder_cout_s, lat);
      end
      @(negedge clk);
      lat++;
    end
    prod = product;
  endtask

  task automatic check_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input int lat, input logic [31:0] prod);
    n_checks++;
    if (prod !== ref_mul(a, b)) begin
      n_fail++;
      $display("FAIL %s product: got %0d want %0d", name, prod, ref_mul(a, b));
    end
    n_checks++;
    if (lat !== LAT) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, LAT);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in1 = 16'd0; in2 = 16'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b product=%0d want 0/0/0", busy, done, product);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bc;
    logic [31:0] p;
    do_op(16'd3, 16'd5, 1'b1, lat, bc, p);
    check_op("basic", 16'd3, 16'd5, lat, p);
    n_checks++;
    if (bc !== 16) begin
      n_fail++;
      $display("FAIL basic busy_cycles: got %0d want 16", bc);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic done_after: got %b want 0", done);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (product !== 32'd15 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic product_hold: got %0d busy=%b want 15 busy=0", product, busy);
    end
  endtask

  task automatic test_max();
    int lat, bc;
    logic [31:0] p;
    do_op(16'hFFFF, 16'hFFFF, 1'b1, lat, bc, p);
    check_op("max", 16'hFFFF, 16'hFFFF, lat, p);
    n_checks++;
    if (p !== 32'hFFFE0001) begin
      n_fail++;
      $display("FAIL max const: got %h want fffe0001", p);
    end
  endtask

  task automatic test_zero();
    int lat, bc;
    logic [31:0] p;
    do_op(16'd0, 16'd12345, 1'b1, lat, bc, p);
    check_op("zero_a", 16'd0, 16'd12345, lat, p);
    do_op(16'd40000, 16'd0, 1'b1, lat, bc, p);
    check_op("zero_b", 16'd40000, 16'd0, lat, p);
  endtask

  task automatic test_start_ignored();
    int lat;
    logic [31:0] p;
    @(negedge clk);
    start = 1'b1; in1 = 16'd100; in2 = 16'd200;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0; in1 = 16'd0; in2 = 16'd0;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 5) begin
        start = 1'b1; in1 = 16'd7; in2 = 16'd7;
      end else begin
        start = 1'b0; in1 = 16'($urandom); in2 = 16'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    p = product;
    check_op("start_in_run", 16'd100, 16'd200, lat, p);
  endtask

  task automatic test_reset_mid_op();
    int lat, bc, seen;
    logic [31:0] p;
    @(negedge clk);
    start = 1'b1; in1 = 16'd1000; in2 = 16'd1000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b done=%b product=%0d want 0/0/0", busy, done, product);
    end
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d done pulses want 0", seen);
    end
    do_op(16'd2, 16'd9, 1'b1, lat, bc, p);
    check_op("after_reset", 16'd2, 16'd9, lat, p);
  endtask

  task automatic test_back_to_back();
    int c, last, ndone;
    @(negedge clk);
    start = 1'b1; in1 = 16'd12; in2 = 16'd11;
    c = 0; last = 0; ndone = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      c++;
      if (done === 1'b1) begin
        n_checks++;
        if (product !== ref_mul(16'd12, 16'd11)) begin
          n_fail++;
          $display("FAIL b2b product: got %0d want %0d", product, ref_mul(16'd12, 16'd11));
        end
        n_checks++;
        if ((ndone == 0 && c !== LAT) || (ndone > 0 && c - last !== 18)) begin
          n_fail++;
          $display("FAIL b2b spacing: got cycle %0d (prev %0d) want 17 then +18", c, last);
        end
        last = c;
        ndone++;
      end
    end
    start = 1'b0;
    n_checks++;
    if (ndone !== 3) begin
      n_fail++;
      $display("FAIL b2b count: got %0d done pulses want 3", ndone);
    end
    c = 0;
    while (done !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, bc;
    logic [15:0] a, b;
    logic [31:0] p;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      do_op(a, b, 1'b1, lat, bc, p);
      check_op("random", a, b, lat, p);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_start_ignored();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
